// File: rtl/acc_display_pkg.sv
// ============================================================================
//  Module   : acc_display_pkg
//  Brief    : Shared opcodes, control-FSM states and seven-segment code table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package acc_display_pkg;

    localparam logic [2:0] OP_SHOW_A = 3'b000;
    localparam logic [2:0] OP_SHOW_B = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_ACC    = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EXEC     = 2'd2,
        ST_HOLD     = 2'd3
    } fsm_state_e;

    // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

`default_nettype wire

// File: rtl/acc_display_if.sv
// ============================================================================
//  Module   : acc_display_if
//  Brief    : Operand/command bus and result/display outputs of acc_display.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface acc_display_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW     = $clog2(DEPTH);
    localparam int DIGITS = (WIDTH + 4) / 4;

    logic [WIDTH-1:0]    IN;
    logic                WEN;
    logic [AW-1:0]       WADDR;
    logic [AW-1:0]       RADDR_A;
    logic [AW-1:0]       RADDR_B;
    logic [2:0]          OP;
    logic [WIDTH:0]      RESULT;
    logic                CARRY;
    logic                OVF;
    logic                VALID;
    logic [7*DIGITS-1:0] HEX;

    modport master (
        output IN, WEN, WADDR, RADDR_A, RADDR_B, OP,
        input  RESULT, CARRY, OVF, VALID, HEX
    );

    modport slave (
        input  IN, WEN, WADDR, RADDR_A, RADDR_B, OP,
        output RESULT, CARRY, OVF, VALID, HEX
    );

endinterface

`default_nettype wire

// File: rtl/acc_display_seg7_hex.sv
// ============================================================================
//  Module   : seg7_hex
//  Brief    : One hex nibble to an active-low seven-segment pattern.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_hex
    import acc_display_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

`default_nettype wire

// File: rtl/acc_display.sv
// ============================================================================
//  Module   : acc_display
//  Brief    : Push-button driven register file / ALU / accumulator with hex display.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module acc_display
    import acc_display_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int DB_CYCLES = 4
) (
    input  wire logic     CLK,
    input  wire logic     RST_N,
    input  wire logic     KEY_N,
    acc_display_if.slave  bus
);

    localparam int DIGITS = (WIDTH + 4) / 4;
    localparam int HW     = 4 * DIGITS;
    localparam int CW     = $clog2(DB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_pressed;
    fsm_state_e       r_state;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH:0]   r_result;
    logic             r_carry;
    logic             r_ovf;
    logic             r_valid;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH:0]   w_accsum;
    logic [HW-1:0]    w_res_ext;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEY_N;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // The IDLE cycle that sees the press is itself the first counted pressed cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pressed) begin
                        r_state <= ST_DEBOUNCE;
                        r_cnt   <= CW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_pressed) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (int'(r_cnt) + 1 >= DB_CYCLES) begin
                        r_state <= ST_EXEC;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_EXEC: r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (!w_pressed) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Operands come from the pre-edge register contents, so a same-index write is not seen
    assign w_a      = r_regs[bus.RADDR_A];
    assign w_b      = r_regs[bus.RADDR_B];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
    assign w_accsum = {1'b0, r_acc} + {1'b0, w_a};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_acc    <= '0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_EXEC);
            if (r_state == ST_EXEC) begin
                if (bus.WEN) begin
                    r_regs[bus.WADDR] <= bus.IN;
                end
                case (bus.OP)
                    OP_SHOW_A: begin
                        r_result <= {1'b0, w_a};
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                    OP_SHOW_B: begin
                        r_result <= {1'b0, w_b};
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                    OP_ADD: begin
                        r_result <= w_sum;
                        r_carry  <= w_sum[WIDTH];
                        r_ovf    <= (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                                    (w_sum[WIDTH-1] != w_a[WIDTH-1]);
                    end
                    OP_SUB: begin
                        r_result <= w_diff;
                        r_carry  <= w_diff[WIDTH];
                        r_ovf    <= (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                                    (w_diff[WIDTH-1] != w_a[WIDTH-1]);
                    end
                    OP_ACC: begin
                        r_acc    <= w_accsum[WIDTH-1:0];
                        r_result <= {1'b0, w_accsum[WIDTH-1:0]};
                        r_carry  <= w_accsum[WIDTH];
                        r_ovf    <= (r_acc[WIDTH-1] == w_a[WIDTH-1]) &&
                                    (w_accsum[WIDTH-1] != r_acc[WIDTH-1]);
                    end
                    OP_CLR: begin
                        r_acc    <= '0;
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.RESULT = r_result;
    assign bus.CARRY  = r_carry;
    assign bus.OVF    = r_ovf;
    assign bus.VALID  = r_valid;

    assign w_res_ext = HW'(r_result);

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            seg7_hex u_seg (
                .nibble (w_res_ext[4*g +: 4]),
                .seg    (bus.HEX[7*g +: 7])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_acc_display.sv
// ============================================================================
//  Module   : tb_acc_display
//  Brief    : Directed and random press sequences against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_acc_display;

    logic CLK = 1'b0;
    logic RST_N;
    logic KEY_N;

    acc_display_if #(.WIDTH(8), .DEPTH(4)) bus ();

    acc_display #(.WIDTH(8), .DEPTH(4), .DB_CYCLES(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .KEY_N (KEY_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_vec = 0;
    int n_err = 0;

    int m_regs [4];
    int m_acc, m_result, m_carry, m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] hex_of(input int r);
        logic [20:0] h;
        for (int i = 0; i < 3; i++) begin
            h[7*i +: 7] = SEG_REF[(r >> (4*i)) & 15];
        end
        return h;
    endfunction

    function automatic int to_s8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    task automatic model_reset;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        m_acc = 0; m_result = 0; m_carry = 0; m_ovf = 0;
    endtask

    task automatic model_exec(input int op, input int ra, input int rb,
                              input int wen, input int wa, input int din);
        int a, b, s;
        a = m_regs[ra];
        b = m_regs[rb];
        case (op)
            0: begin m_result = a; m_carry = 0; m_ovf = 0; end
            1: begin m_result = b; m_carry = 0; m_ovf = 0; end
            2: begin
                m_result = a + b;
                m_carry  = (a + b > 255);
                s        = to_s8(a) + to_s8(b);
                m_ovf    = (s > 127 || s < -128);
            end
            3: begin
                m_result = (a - b + 512) % 512;
                m_carry  = (a < b);
                s        = to_s8(a) - to_s8(b);
                m_ovf    = (s > 127 || s < -128);
            end
            4: begin
                m_carry  = (m_acc + a > 255);
                s        = to_s8(m_acc) + to_s8(a);
                m_ovf    = (s > 127 || s < -128);
                m_acc    = (m_acc + a) % 256;
                m_result = m_acc;
            end
            5: begin m_acc = 0; m_result = 0; m_carry = 0; m_ovf = 0; end
            default: ;
        endcase
        if (wen != 0) m_regs[wa] = din;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_result"}, bus.RESULT, m_result);
        check({tag, "_carry"},  bus.CARRY,  m_carry);
        check({tag, "_ovf"},    bus.OVF,    m_ovf);
        check({tag, "_hex"},    bus.HEX,    hex_of(m_result));
    endtask

    task automatic set_inputs(input int op, input int ra, input int rb,
                              input int wen, input int wa, input int din);
        bus.OP      = op[2:0];
        bus.RADDR_A = ra[1:0];
        bus.RADDR_B = rb[1:0];
        bus.WEN     = wen[0];
        bus.WADDR   = wa[1:0];
        bus.IN      = din[7:0];
    endtask

    // One qualified press: latency, result, single pulse, no effect of later input changes
    task automatic press(input string tag, input int op, input int ra, input int rb,
                         input int wen, input int wa, input int din, input int hold);
        int n, got, extra;
        @(negedge CLK);
        set_inputs(op, ra, rb, wen, wa, din);
        KEY_N = 1'b0;
        n = 0; got = 0;
        while (n < 20 && got == 0) begin
            @(negedge CLK);
            n++;
            if (bus.VALID === 1'b1) got = 1;
        end
        check({tag, "_latency"}, (got == 1 && n >= 6 && n <= 8), 1);
        model_exec(op, ra, rb, wen, wa, din);
        check_outputs(tag);
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        extra = 0;
        repeat (hold) begin
            @(negedge CLK);
            if (bus.VALID !== 1'b0) extra++;
        end
        KEY_N = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            if (bus.VALID !== 1'b0) extra++;
        end
        check({tag, "_single_valid"}, extra, 0);
        check({tag, "_held_result"}, bus.RESULT, m_result);
    endtask

    initial begin
        int extra, n, got;
        model_reset();
        KEY_N = 1'b1;
        RST_N = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge CLK);
        check("rst_result", bus.RESULT, 0);
        check("rst_flags", {bus.CARRY, bus.OVF, bus.VALID}, 0);
        check("rst_hex", bus.HEX, {3{7'b1000000}});
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Known-answer sums and differences
        press("wr_r0", 6, 0, 0, 1, 0, 'h5A, 2);
        press("wr_r1", 7, 0, 0, 1, 1, 'hC3, 2);
        press("add_5a_c3", 2, 0, 1, 0, 0, 0, 2);
        check("add_5a_c3_const", {bus.CARRY, bus.OVF, bus.RESULT}, {1'b1, 1'b0, 9'h11D});
        check("add_5a_c3_digits", bus.HEX, {7'b1111001, 7'b1111001, 7'b0100001});
        press("wr_r0b", 6, 0, 0, 1, 0, 'h05, 2);
        press("wr_r1b", 6, 0, 0, 1, 1, 'h07, 2);
        press("sub_5_7", 3, 0, 1, 0, 0, 0, 2);
        check("sub_5_7_const", {bus.CARRY, bus.RESULT}, {1'b1, 9'h1FE});
        press("wr_r0c", 6, 0, 0, 1, 0, 'h7F, 2);
        press("wr_r1c", 6, 0, 0, 1, 1, 'h01, 2);
        press("add_ovf", 2, 0, 1, 0, 0, 0, 2);
        check("add_ovf_const", {bus.CARRY, bus.OVF, bus.RESULT}, {1'b0, 1'b1, 9'h080});

        // A 3-cycle tap must not qualify
        @(negedge CLK);
        KEY_N = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.VALID !== 1'b0) extra++;
        end
        KEY_N = 1'b1;
        repeat (12) begin
            @(negedge CLK);
            if (bus.VALID !== 1'b0) extra++;
        end
        check("short_press_no_valid", extra, 0);
        check("short_press_result", bus.RESULT, m_result);

        press("long_press", 1, 0, 1, 0, 0, 0, 50);

        // Accumulator wrap and clear
        press("wr_r2", 5, 0, 0, 1, 2, 'h80, 2);
        press("acc1", 4, 2, 0, 0, 0, 0, 2);
        check("acc1_const", bus.RESULT, 9'h080);
        press("acc2", 4, 2, 0, 0, 0, 0, 2);
        check("acc2_const", {bus.CARRY, bus.RESULT}, {1'b1, 9'h000});
        press("clr", 5, 0, 0, 0, 0, 0, 2);
        press("acc_after_clr", 4, 1, 0, 0, 0, 0, 2);
        check("acc_after_clr_const", bus.RESULT, 9'h001);

        // Same-index write and read uses the old value
        press("wr_r0d", 6, 0, 0, 1, 0, 'h01, 2);
        press("rw_same", 2, 0, 0, 1, 0, 'h10, 2);
        check("rw_same_const", bus.RESULT, 9'h002);
        press("show_new", 0, 0, 0, 0, 0, 0, 2);
        check("show_new_const", bus.RESULT, 9'h010);

        // Reset during HOLD after a write to r2
        @(negedge CLK);
        set_inputs(1, 0, 1, 1, 2, 'h55);
        KEY_N = 1'b0;
        n = 0; got = 0;
        while (n < 20 && got == 0) begin
            @(negedge CLK);
            n++;
            if (bus.VALID === 1'b1) got = 1;
        end
        check("hold_rst_pre_valid", got, 1);
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("hold_rst_result", bus.RESULT, 0);
        check("hold_rst_flags", {bus.CARRY, bus.OVF, bus.VALID}, 0);
        check("hold_rst_hex", bus.HEX, {3{7'b1000000}});
        KEY_N = 1'b1;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        repeat (2) @(negedge CLK);
        press("show_r2_after_rst", 0, 2, 0, 0, 0, 0, 2);

        // Random sequence
        for (int k = 0; k < 40; k++) begin
            press("rand", $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/acc_display.md
ACC_DISPLAY -- requirements
Module: acc_display

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits (legal values 4 to 32).
REQ-002 Parameter DEPTH, default 4: number of operand registers (power of 2, at least 2).
REQ-003 Parameter DB_CYCLES, default 4: debounce length in clock cycles (at least 1).
REQ-004 Derived constants: AW = $clog2(DEPTH); DIGITS = ceil((WIDTH+1)/4).
REQ-005 CLK  input  1: single clock; all state SHALL change on the rising edge.
REQ-006 RST_N  input  1: asynchronous, active-low reset.
REQ-007 KEY_N  input  1: raw, asynchronous, active-low GO push-button.
REQ-008 IN  input  WIDTH: write data.
REQ-009 WEN  input  1: write IN to register WADDR on execute.
REQ-010 WADDR  input  AW: write register index.
REQ-011 RADDR_A, RADDR_B  input  AW each: indices of operands A and B.
REQ-012 OP  input  3: operation select. 000 = SHOW_A, 001 = SHOW_B, 010 = ADD, 011 = SUB, 100 = ACC, 101 = CLR, 11x = NOP.
REQ-013 RESULT  output  WIDTH+1: registered result.
REQ-014 CARRY, OVF  output  1 each: registered flags.
REQ-015 VALID  output  1: one-cycle pulse after each execute.
REQ-016 HEX  output  7*DIGITS: active-low segments {g,f,e,d,c,b,a}; digit i at bits [7i+6:7i], digit 0 least significant.

Function
REQ-017 KEY_N SHALL pass through a 2-flop synchroniser whose flops reset to 1 (released); all control SHALL use the synchronised "pressed" level.
REQ-018 The control FSM SHALL have four states: IDLE, DEBOUNCE, EXEC, HOLD.
- IDLE: goes to DEBOUNCE when pressed.
- DEBOUNCE: counts consecutive pressed cycles. A release returns it to IDLE with the count cleared. When the count reaches DB_CYCLES, go to EXEC.
- EXEC: lasts exactly one cycle, then goes to HOLD.
- HOLD: returns to IDLE on the first released cycle.
REQ-019 Exactly one EXEC SHALL occur per qualified press, however long the key is held.
REQ-020 In EXEC, if WEN = 1, reg[WADDR] <= IN. Operands A and B SHALL be read from pre-write register values, so a simultaneous write and read of the same index uses the old value.
REQ-021 Updates performed in EXEC, by operation:
- SHOW_A / SHOW_B: RESULT <= zero-extended A / B; CARRY = 0; OVF = 0.
- ADD: RESULT <= A + B unsigned in WIDTH+1 bits; CARRY = RESULT[WIDTH]; OVF = signed two's-complement overflow of the WIDTH-bit sum.
- SUB: RESULT <= {borrow, (A - B) mod 2^WIDTH}; CARRY = borrow (1 iff A < B unsigned); OVF = signed overflow of the difference.
- ACC: ACC <= (ACC + A) mod 2^WIDTH; RESULT <= zero-extended new ACC; CARRY = wrap-out bit; OVF = signed overflow.
- CLR: ACC, RESULT, CARRY and OVF <= 0; registers are unchanged.
- NOP: RESULT, flags and ACC hold; the write still occurs.
REQ-022 RESULT, CARRY, OVF and ACC SHALL update on the edge that leaves EXEC; VALID SHALL be 1 for exactly the following cycle.
REQ-023 Latency from KEY_N falling (held stable) to VALID high SHALL be 2 + DB_CYCLES + 1 cycles, ±1 for input synchroniser phase.
REQ-024 HEX SHALL be a combinational decode of RESULT zero-extended to 4*DIGITS bits.
REQ-025 Digit codes: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110. Every nibble value SHALL have exactly one code.
REQ-026 Input values other than KEY_N SHALL be sampled only in EXEC; changes in all other states SHALL have no effect.

Reset
REQ-027 RST_N low SHALL immediately force:
- all registers, ACC, RESULT, CARRY, OVF and VALID to 0;
- the FSM to IDLE with the debounce count cleared;
- both synchroniser flops to 1.
REQ-028 During reset, HEX SHALL show '0' (1000000) on every digit.
REQ-029 Reset asserted in any FSM state, including mid-DEBOUNCE and HOLD, SHALL abort the operation with no register write.
REQ-030 After RST_N deasserts, a key still held SHALL qualify only after a fresh 2 + DB_CYCLES cycles.

Structure
REQ-031 A shared package SHALL hold the OP encodings, the FSM state enum and the 16-entry segment constant table.
REQ-032 One sub-module, seg7_hex (4-bit in, 7-bit active-low out), SHALL be instantiated DIGITS times through a generate loop.

Verification (WIDTH=8, DEPTH=4, DB_CYCLES=4)
REQ-033 Write 0x5A to r0 and 0xC3 to r1, then ADD with A = r0, B = r1 -> RESULT = 0x11D, CARRY = 1, OVF = 0, HEX digits 2..0 = 1, 1, d.
REQ-034 SUB with r0 = 0x05, r1 = 0x07 -> RESULT = 0x1FE, CARRY = 1. ADD 0x7F + 0x01 -> RESULT = 0x080, OVF = 1, CARRY = 0.
REQ-035 KEY_N low for 3 cycles, then high -> no EXEC and VALID stays 0. KEY_N low for 50 cycles -> exactly one VALID pulse, 7 (±1) cycles after the falling edge.
REQ-036 A = 0x80; ACC twice -> RESULT 0x080 then 0x000 with CARRY = 1. Then CLR -> RESULT = 0 and ACC = 0.
REQ-037 WEN = 1, WADDR = 0, IN = 0x10 with r0 = 0x01 and ADD of r0 + r0 -> RESULT = 0x002; a subsequent SHOW_A -> RESULT = 0x010.
REQ-038 RST_N pulsed low during HOLD after writing r2 -> all outputs 0, HEX = 1000000 ×3, and SHOW_A of r2 -> RESULT = 0.
